// File: rtl/rx_disp_pkg.sv
// Shared types and the type-mask routing helpers for the RX message dispatcher.
package rx_disp_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, OFFER, DROP} disp_state_e;

  localparam int MSG_TYPE_W    = 4;
  localparam int MSG_PAYLOAD_W = 160;

  typedef struct packed {
    logic                     valid;
    logic [MSG_TYPE_W-1:0]    mtype;
    logic [MSG_PAYLOAD_W-1:0] payload;
  } msg_entry_t;

  // Route masks are widened to this fixed size so the helpers stay parameter-free.
  localparam int MAX_HDL   = 16;
  localparam int MAX_TYPES = 256;
  localparam int MASK_MAX  = MAX_HDL * MAX_TYPES;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } owner_t;

  function automatic logic owns(input logic [MASK_MAX-1:0] mask, input int hdl,
                                input int mtype, input int n_types);
    logic [MASK_MAX-1:0] sh;
    sh = mask >> (hdl * n_types + mtype);
    return sh[0];
  endfunction

  function automatic owner_t first_owner(input logic [MASK_MAX-1:0] mask, input int mtype,
                                         input int n_hdl, input int n_types);
    owner_t r;
    r = '0;
    for (int h = MAX_HDL - 1; h >= 0; h--) begin
      if (h < n_hdl && owns(mask, h, mtype, n_types)) begin
        r.found = 1'b1;
        r.idx   = 4'(h);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Small synchronous FIFO with occupancy output; head is visible combinationally on dout.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/rx_msg_dispatcher.sv
// Buffers classified RX messages and routes each to one handler by type mask, with
// burst lock, offer watchdog and saturating error counters.
// state  | meaning
// IDLE   | waiting for a buffered message
// LOOKUP | resolving the target handler of the FIFO head
// OFFER  | head offered to the target, waiting for ack or watchdog expiry
// DROP   | discarding an invalid or unowned head
module rx_msg_dispatcher #(
  parameter int NUM_HDL     = 3,
  parameter int TYPE_W      = 4,
  parameter int PAYLOAD_W   = 160,
  parameter int DEPTH       = 4,
  parameter logic [NUM_HDL*(2**TYPE_W)-1:0] ROUTE_MASK = '0,
  parameter int BURST_HDL   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_available,
  input  logic                       valid_msg,
  input  logic                       burst_on,
  input  logic [TYPE_W-1:0]          msg_type,
  input  logic [PAYLOAD_W-1:0]       msg_payload,
  output logic                       seq_ready,
  output logic [NUM_HDL-1:0]         hdl_valid,
  output logic [TYPE_W-1:0]          hdl_type,
  output logic [PAYLOAD_W-1:0]       hdl_payload,
  input  logic [NUM_HDL-1:0]         hdl_ack,
  input  logic                       cnt_clr,
  output logic                       unrouted_err,
  output logic                       timeout_err,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           timeout_cnt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy
);
  import rx_disp_pkg::*;

  localparam int NTYPES = 2**TYPE_W;
  localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]     WD_INIT   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [MASK_MAX-1:0] MASK_EXT  = MASK_MAX'(ROUTE_MASK);
  localparam logic [NUM_HDL-1:0]  BURST_VEC = NUM_HDL'(1) << BURST_HDL;

  typedef struct packed {
    logic                 valid;
    logic [TYPE_W-1:0]    mtype;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  disp_state_e         state;
  entry_t              wr_entry;
  entry_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                armed;
  logic                accept;
  logic                pop;
  logic                ack_hit;
  logic                expired;
  logic                burst_owns;
  owner_t              owner;
  logic [NUM_HDL-1:0]  offer_vec;
  logic [WD_W-1:0]     wd;

  assign wr_entry = {valid_msg, msg_type, msg_payload};
  assign accept   = data_available && armed && !fifo_full;

  msg_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign owner      = first_owner(MASK_EXT, int'(head.mtype), NUM_HDL, NTYPES);
  assign burst_owns = owns(MASK_EXT, BURST_HDL, int'(head.mtype), NTYPES);

  // While burst is on only the burst handler may take the head; others wait in LOOKUP.
  always_comb begin
    offer_vec = '0;
    if (burst_on) begin
      if (burst_owns) offer_vec = BURST_VEC;
    end else if (owner.found) begin
      offer_vec = NUM_HDL'(1) << owner.idx;
    end
  end

  assign ack_hit = |(hdl_ack & hdl_valid);
  assign expired = (wd == '0);
  assign pop     = ((state == OFFER) && (ack_hit || expired)) || (state == DROP);
  assign busy    = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b1;
      seq_ready <= 1'b0;
    end else begin
      seq_ready <= accept;
      if (accept)               armed <= 1'b0;
      else if (!data_available) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hdl_valid    <= '0;
      hdl_type     <= '0;
      hdl_payload  <= '0;
      unrouted_err <= 1'b0;
      timeout_err  <= 1'b0;
      wd           <= '0;
    end else begin
      unrouted_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: if (accept || !fifo_empty) state <= LOOKUP;
        LOOKUP: begin
          if (!head.valid) begin
            state <= DROP;
          end else if (|offer_vec) begin
            hdl_valid   <= offer_vec;
            hdl_type    <= head.mtype;
            hdl_payload <= head.payload;
            wd          <= WD_INIT;
            state       <= OFFER;
          end else if (!burst_on) begin
            state <= DROP;
          end
        end
        OFFER: begin
          if (ack_hit) begin
            hdl_valid <= '0;
            state     <= IDLE;
          end else if (expired) begin
            hdl_valid   <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd - WD_W'(1);
          end
        end
        DROP: begin
          unrouted_err <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else if (cnt_clr) begin
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (state == DROP && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (state == OFFER && !ack_hit && expired && timeout_cnt != '1)
        timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

endmodule
